// File: rtl/rat_flags.sv
// rat_flags: C/Z/I flag registers for the RAT CPU, with C/Z shadow copies
// for interrupt entry/return and a synchronised, edge-qualified interrupt
// request. Every output is a register or an AND of registers.
module rat_flags #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INTR,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic INT_REQ
);

    logic [SYNC_STAGES-1:0] intr_sync;
    logic                   intr_s;
    logic                   intr_d;
    logic                   intr_rise;
    logic                   pending;
    logic                   c_ld_src;
    logic                   z_ld_src;

    // Flag load source: ALU result normally, shadow copy on RETI/RETIE
    assign c_ld_src  = FLG_LD_SEL ? SHAD_C : C_IN;
    assign z_ld_src  = FLG_LD_SEL ? SHAD_Z : Z_IN;

    assign intr_s    = intr_sync[SYNC_STAGES-1];
    assign intr_rise = intr_s & ~intr_d;

    // Carry: clear beats set beats load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            C_FLAG <= 1'b0;
        end else if (FLG_C_CLR) begin
            C_FLAG <= 1'b0;
        end else if (FLG_C_SET) begin
            C_FLAG <= 1'b1;
        end else if (FLG_C_LD) begin
            C_FLAG <= c_ld_src;
        end
    end

    // Zero flag: load or hold only
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Z_FLAG <= 1'b0;
        end else if (FLG_Z_LD) begin
            Z_FLAG <= z_ld_src;
        end
    end

    // Shadow captures the pre-edge flags, so a same-cycle C load still saves the old C
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SHAD_C <= 1'b0;
            SHAD_Z <= 1'b0;
        end else if (FLG_SHAD_LD) begin
            SHAD_C <= C_FLAG;
            SHAD_Z <= Z_FLAG;
        end
    end

    // Interrupt enable: entry clears it ahead of any CLI/SEI in the same cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            I_FLAG <= 1'b0;
        end else if (FLG_SHAD_LD) begin
            I_FLAG <= 1'b0;
        end else if (I_CLR) begin
            I_FLAG <= 1'b0;
        end else if (I_SET) begin
            I_FLAG <= 1'b1;
        end
    end

    // Synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            intr_sync <= '0;
            intr_d    <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                intr_sync <= {intr_sync[SYNC_STAGES-2:0], INTR};
            end else begin
                intr_sync <= {SYNC_STAGES{INTR}};
            end
            intr_d <= intr_s;
        end
    end

    // Pending request: a new edge wins over the entry clear so it is never lost
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= 1'b0;
        end else if (intr_rise) begin
            pending <= 1'b1;
        end else if (FLG_SHAD_LD) begin
            pending <= 1'b0;
        end
    end

    assign INT_REQ = pending & I_FLAG;

endmodule

// File: tb/tb_rat_flags.sv
// tb_rat_flags: directed bench for rat_flags with hand-computed expectations.
module tb_rat_flags;

    logic CLK;
    logic RST;
    logic C_IN, Z_IN;
    logic FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR, FLG_LD_SEL, FLG_SHAD_LD;
    logic I_SET, I_CLR, INTR;
    logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ;

    int checks   = 0;
    int failures = 0;
    int req_cnt;
    logic shad_next, iset_next;

    rat_flags #(.SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_IN       (C_IN),
        .Z_IN       (Z_IN),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_LD_SEL (FLG_LD_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET      (I_SET),
        .I_CLR      (I_CLR),
        .INTR       (INTR),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .I_FLAG     (I_FLAG),
        .SHAD_C     (SHAD_C),
        .SHAD_Z     (SHAD_Z),
        .INT_REQ    (INT_REQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_C"},   C_FLAG,  1'b0);
        check({tag, "_Z"},   Z_FLAG,  1'b0);
        check({tag, "_I"},   I_FLAG,  1'b0);
        check({tag, "_SC"},  SHAD_C,  1'b0);
        check({tag, "_SZ"},  SHAD_Z,  1'b0);
        check({tag, "_REQ"}, INT_REQ, 1'b0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        C_IN = 0; Z_IN = 0; FLG_C_LD = 0; FLG_Z_LD = 0; FLG_C_SET = 0;
        FLG_C_CLR = 0; FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0;
    endtask

    initial begin
        RST = 1'b0;
        INTR = 1'b0;
        idle_inputs();

        // Reset asserted between edges clears everything at once
        #2 RST = 1'b1;
        #1 check_all_zero("rst_imm");
        for (int i = 0; i < 5; i++) begin
            {C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET} = 5'($urandom);
            {FLG_C_CLR, FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INTR} = 6'($urandom);
            step();
            check_all_zero("rst_hold");
        end
        idle_inputs();
        INTR = 1'b0;
        step();
        RST = 1'b0;
        step();
        check_all_zero("rst_rel");

        // ALU load, then SET+CLR together gives C=0 while Z holds
        C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        step();
        idle_inputs();
        check("alu_ld_C", C_FLAG, 1'b1);
        check("alu_ld_Z", Z_FLAG, 1'b1);
        FLG_C_SET = 1; FLG_C_CLR = 1;
        step();
        idle_inputs();
        check("setclr_C", C_FLAG, 1'b0);
        check("setclr_Zhold", Z_FLAG, 1'b1);

        // Establish C=1, Z=0, I=1
        FLG_C_SET = 1; Z_IN = 0; FLG_Z_LD = 1; I_SET = 1;
        step();
        idle_inputs();
        check("prep_C", C_FLAG, 1'b1);
        check("prep_Z", Z_FLAG, 1'b0);
        check("prep_I", I_FLAG, 1'b1);

        // One-cycle INTR pulse: request after the third edge
        INTR = 1;
        step();
        INTR = 0;
        check("lat_e1", INT_REQ, 1'b0);
        step();
        check("lat_e2", INT_REQ, 1'b0);
        step();
        check("lat_e3", INT_REQ, 1'b1);

        // Interrupt entry with a simultaneous C load
        FLG_SHAD_LD = 1; C_IN = 0; FLG_C_LD = 1;
        step();
        idle_inputs();
        check("entry_SC", SHAD_C, 1'b1);
        check("entry_SZ", SHAD_Z, 1'b0);
        check("entry_C", C_FLAG, 1'b0);
        check("entry_I", I_FLAG, 1'b0);
        check("entry_REQ", INT_REQ, 1'b0);

        // RETIE: restore from shadow; ALU inputs deliberately opposite
        FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; I_SET = 1; C_IN = 0; Z_IN = 1;
        step();
        idle_inputs();
        check("retie_C", C_FLAG, 1'b1);
        check("retie_Z", Z_FLAG, 1'b0);
        check("retie_I", I_FLAG, 1'b1);
        check("retie_REQ", INT_REQ, 1'b0);

        // Masked interrupt: edge while I=0 is remembered
        I_CLR = 1;
        step();
        idle_inputs();
        check("mask_I", I_FLAG, 1'b0);
        INTR = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("mask_REQ", INT_REQ, 1'b0);
        end
        I_SET = 1;
        step();
        idle_inputs();
        check("mask_late_REQ", INT_REQ, 1'b1);
        FLG_SHAD_LD = 1;
        step();
        idle_inputs();
        check("mask_clr_REQ", INT_REQ, 1'b0);

        // Level hold: one request only while INTR stays high
        INTR = 0; I_SET = 1;
        step();
        idle_inputs();
        step(); step(); step();
        INTR = 1;
        req_cnt = 0; shad_next = 0; iset_next = 0;
        for (int i = 0; i < 20; i++) begin
            FLG_SHAD_LD = shad_next;
            I_SET = iset_next;
            step();
            iset_next = shad_next;
            shad_next = 0;
            if (INT_REQ === 1'b1) begin
                req_cnt++;
                shad_next = 1;
            end
        end
        idle_inputs();
        check_int("level_once", req_cnt, 1);
        check("level_I", I_FLAG, 1'b1);

        // Drop and re-raise: second request with the usual latency
        INTR = 0;
        step(); step(); step();
        INTR = 1;
        step();
        check("second_e1", INT_REQ, 1'b0);
        step();
        check("second_e2", INT_REQ, 1'b0);
        step();
        check("second_e3", INT_REQ, 1'b1);
        FLG_SHAD_LD = 1;
        step();
        idle_inputs();
        check("second_clr", INT_REQ, 1'b0);

        // Collision: new edge lands in the same cycle as interrupt entry
        INTR = 0;
        step(); step(); step();
        INTR = 1;
        step();
        step();
        FLG_SHAD_LD = 1;
        step();
        idle_inputs();
        check("coll_I", I_FLAG, 1'b0);
        check("coll_REQ", INT_REQ, 1'b0);
        I_SET = 1;
        step();
        idle_inputs();
        check("coll_kept", INT_REQ, 1'b1);

        // Reset mid-operation with INTR held high across release
        I_SET = 1;
        #2 RST = 1'b1;
        #1 check_all_zero("mid_rst");
        #1 RST = 1'b0;
        step();
        check("rel_I", I_FLAG, 1'b1);
        check("rel_e1", INT_REQ, 1'b0);
        step();
        check("rel_e2", INT_REQ, 1'b0);
        step();
        check("rel_e3", INT_REQ, 1'b1);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rat_flags.md
Name: rat_flags

Overview:
- Flag/interrupt-state unit for the RAT CPU; the consumer end of the ALU's C/Z outputs and the source of the ALU's CIN.
- Registers C and Z and the interrupt-enable flag I.
- Keeps shadow copies of C/Z for interrupt entry and RETI/RETIE restore.
- Synchronises the external interrupt line and presents a qualified interrupt request to the control unit.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the INTR synchroniser (minimum 2).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- C_IN  in  1  carry result from ALU (C).
- Z_IN  in  1  zero result from ALU (Z).
- FLG_C_LD  in  1  load C from C_IN (or shadow when FLG_LD_SEL=1).
- FLG_Z_LD  in  1  load Z from Z_IN (or shadow when FLG_LD_SEL=1).
- FLG_C_SET  in  1  force C=1 (SEC).
- FLG_C_CLR  in  1  force C=0 (CLC).
- FLG_LD_SEL  in  1  0: load source is ALU; 1: load source is shadow (RETI/RETIE).
- FLG_SHAD_LD  in  1  interrupt entry: copy C/Z to shadow, clear I, clear pending.
- I_SET  in  1  SEI / RETIE: I=1.
- I_CLR  in  1  CLI / RETI: I=0.
- INTR  in  1  external interrupt line, asynchronous to CLK, level-high.
- C_FLAG  out  1  registered carry; drives ALU CIN.
- Z_FLAG  out  1  registered zero.
- I_FLAG  out  1  registered interrupt enable.
- SHAD_C  out  1  shadow carry.
- SHAD_Z  out  1  shadow zero.
- INT_REQ  out  1  interrupt request to control unit.

Behaviour:
- Reset (async, immediate): C_FLAG=0, Z_FLAG=0, I_FLAG=0, SHAD_C=0, SHAD_Z=0, synchroniser chain=0, pending=0, INT_REQ=0.
- All outputs are registered or pure ANDs of registers; no combinational path from any input to any output.

C priority, per cycle, highest first:
- FLG_C_CLR, then FLG_C_SET, then FLG_C_LD, else hold.
- Load source: C_IN when FLG_LD_SEL=0; SHAD_C when FLG_LD_SEL=1.
- CLR and SET together: C=0.

Z:
- FLG_Z_LD loads Z_IN (FLG_LD_SEL=0) or SHAD_Z (FLG_LD_SEL=1); else hold.
- No set/clear controls.

Shadow:
- On FLG_SHAD_LD: SHAD_C<=C_FLAG and SHAD_Z<=Z_FLAG, using pre-edge values.
- If FLG_SHAD_LD and FLG_C_LD occur in the same cycle, the shadow captures the old C and C_FLAG takes the new value.
- Shadow holds otherwise.

I flag, priority highest first:
- FLG_SHAD_LD clears I, then I_CLR, then I_SET, else hold.
- Simultaneous FLG_SHAD_LD and I_SET: I=0.

Interrupt path:
- INTR passes through SYNC_STAGES flops to give intr_s; one extra flop gives intr_d.
- Rising edge = intr_s & ~intr_d.
- pending set on a rising edge; cleared by FLG_SHAD_LD; set wins over clear in the same cycle (new edge not lost).
- Edge while I=0 still sets pending; the request is serviced once I is later set.
- INT_REQ = pending & I_FLAG.
- Latency: INTR rise at edge n gives INT_REQ=1 after edge n+SYNC_STAGES+1 when I=1.
- INTR held high produces exactly one request until it deasserts and rises again.

Reset mid-operation:
- All state including pending clears immediately.
- An INTR held high across reset release is not a new edge until the synchroniser fills: it produces one request SYNC_STAGES+1 cycles after release.

Test Plan:
- Reset: RST=1 with random inputs toggling -> all six outputs 0 immediately, stay 0 while RST=1.
- ALU load: C_IN=1, Z_IN=1, FLG_C_LD=FLG_Z_LD=1, FLG_LD_SEL=0 for one cycle -> C_FLAG=1, Z_FLAG=1 next edge; then FLG_C_SET=FLG_C_CLR=1 -> C_FLAG=0, Z_FLAG holds 1.
- Interrupt entry/exit: C=1, Z=0, I=1; pulse INTR -> INT_REQ=1 after 3 edges (SYNC_STAGES=2).
  - FLG_SHAD_LD with C_IN=0, FLG_C_LD=1 -> SHAD_C=1, SHAD_Z=0, C_FLAG=0, I_FLAG=0, INT_REQ=0.
  - Then FLG_LD_SEL=1, FLG_C_LD=FLG_Z_LD=1, I_SET=1 -> C_FLAG=1, Z_FLAG=0, I_FLAG=1.
- Masked interrupt: I=0, INTR 0->1 -> INT_REQ stays 0; assert I_SET 10 cycles later -> INT_REQ=1 next edge.
- Level hold: INTR held 1 for 20 cycles with I=1, FLG_SHAD_LD pulsed once INT_REQ=1 -> exactly one INT_REQ assertion; drop INTR and raise again -> second request.
- Collision: new INTR edge detected in the same cycle as FLG_SHAD_LD -> pending stays 1, INT_REQ=1 once I_SET applied.
